// File: rtl/debug_display_ctrl.sv
// Debug front-panel controller: selects a pipeline channel or register value, converts it
// digit by digit to decimal or hex, and drives double-buffered seven-segment displays and LEDs.
module debug_display_ctrl #(
    parameter int unsigned NUM_CH     = 7,
    parameter int unsigned VAL_W      = 32,
    parameter int unsigned OP_W       = 7,
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned LED_W      = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*VAL_W-1:0] ch_value,
    input  logic [NUM_CH*OP_W-1:0]  ch_opcode,
    input  logic [VAL_W-1:0]        reg_value,
    input  logic [9:0]              SW,
    output logic [NUM_DIGITS*7-1:0] HEX,
    output logic [LED_W-1:0]        LEDR,
    output logic                    busy
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StConv, StCommit} state_e;

    state_e                  state_q, state_d;
    logic [VAL_W-1:0]        work_q, work_d;
    logic [VAL_W-1:0]        snap_value_q, snap_value_d;
    logic [4:0]              snap_mode_q, snap_mode_d;
    logic [VAL_W-1:0]        shown_value_q, shown_value_d;
    logic [4:0]              shown_mode_q, shown_mode_d;
    logic                    shown_valid_q, shown_valid_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    busy_q, busy_d;
    logic [3:0]              shadow_q [NUM_DIGITS];
    logic [3:0]              shadow_d [NUM_DIGITS];
    logic [NUM_DIGITS*7-1:0] hex_q, hex_d;
    logic [LED_W-1:0]        ledr_q, ledr_d;

    logic [VAL_W-1:0]        target;
    logic [OP_W-1:0]         opcode;
    logic [4:0]              mode;
    logic [3:0]              digit;
    logic [VAL_W-1:0]        quot;
    logic [NUM_DIGITS*7-1:0] commit_hex;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Out-of-range channel selects read as zero value and zero opcode.
    always_comb begin
        target = '0;
        opcode = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (SW[2:0] == 3'(k)) begin
                target = ch_value[k*VAL_W +: VAL_W];
                opcode = ch_opcode[k*OP_W +: OP_W];
            end
        end
        if (SW[9]) target = reg_value;
    end

    assign mode  = {SW[9], SW[8], SW[2:0]};
    assign digit = snap_mode_q[3] ? work_q[3:0] : 4'(work_q % VAL_W'(10));
    assign quot  = snap_mode_q[3] ? (work_q >> 4) : (work_q / VAL_W'(10));

    // Leftover quotient after the last digit means the value does not fit: show dashes.
    always_comb begin
        logic seen;
        commit_hex = '1;
        seen       = 1'b0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            if (shadow_q[d] != 4'd0 || d == 0) seen = 1'b1;
            if (work_q != '0) commit_hex[d*7 +: 7] = 7'b0111111;
            else if (seen)    commit_hex[d*7 +: 7] = glyph(shadow_q[d]);
            else              commit_hex[d*7 +: 7] = 7'h7F;
        end
    end

    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        snap_value_d  = snap_value_q;
        snap_mode_d   = snap_mode_q;
        shown_value_d = shown_value_q;
        shown_mode_d  = shown_mode_q;
        shown_valid_d = shown_valid_q;
        idx_d         = idx_q;
        busy_d        = busy_q;
        shadow_d      = shadow_q;
        hex_d         = hex_q;
        case (state_q)
            StIdle: begin
                if (!SW[7] && (!shown_valid_q || target != shown_value_q ||
                               mode != shown_mode_q)) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                work_d       = target;
                snap_value_d = target;
                snap_mode_d  = mode;
                idx_d        = '0;
                busy_d       = 1'b1;
                state_d      = StConv;
            end
            StConv: begin
                shadow_d[idx_q] = digit;
                work_d          = quot;
                if (idx_q == LAST_IDX) state_d = StCommit;
                else                   idx_d   = idx_q + 1'b1;
            end
            StCommit: begin
                hex_d         = commit_hex;
                shown_value_d = snap_value_q;
                shown_mode_d  = snap_mode_q;
                shown_valid_d = 1'b1;
                busy_d        = 1'b0;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // LED bar shows the opcode bit-reversed so its MSB lands on LEDR[0].
    always_comb begin
        ledr_d = '0;
        if (SW[9]) begin
            ledr_d = '1;
        end else begin
            for (int i = 0; i < OP_W; i++) ledr_d[i] = opcode[OP_W-1-i];
            ledr_d[LED_W-1] = busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            work_q        <= '0;
            snap_value_q  <= '0;
            snap_mode_q   <= '0;
            shown_value_q <= '0;
            shown_mode_q  <= '0;
            shown_valid_q <= 1'b0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) shadow_q[d] <= '0;
            hex_q         <= '1;
            ledr_q        <= '0;
        end else begin
            state_q       <= state_d;
            work_q        <= work_d;
            snap_value_q  <= snap_value_d;
            snap_mode_q   <= snap_mode_d;
            shown_value_q <= shown_value_d;
            shown_mode_q  <= shown_mode_d;
            shown_valid_q <= shown_valid_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            for (int d = 0; d < NUM_DIGITS; d++) shadow_q[d] <= shadow_d[d];
            hex_q         <= hex_d;
            ledr_q        <= ledr_d;
        end
    end

    assign HEX  = hex_q;
    assign LEDR = ledr_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debug_display_ctrl.sv
// Scoreboard bench for debug_display_ctrl: expected frames are queued from an arithmetic model
// when stimulus is applied and popped by a monitor at each commit.
module tb_debug_display_ctrl;

    localparam int NUM_CH = 7;
    localparam int VAL_W  = 32;
    localparam int OP_W   = 7;
    localparam int ND     = 6;
    localparam int LED_W  = 10;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH*VAL_W-1:0] ch_value = '0;
    logic [NUM_CH*OP_W-1:0]  ch_opcode = '0;
    logic [VAL_W-1:0]        reg_value = '0;
    logic [9:0]              SW = '0;
    logic [ND*7-1:0]         HEX;
    logic [LED_W-1:0]        LEDR;
    logic                    busy;

    debug_display_ctrl #(
        .NUM_CH(NUM_CH), .VAL_W(VAL_W), .OP_W(OP_W), .NUM_DIGITS(ND), .LED_W(LED_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_value(ch_value), .ch_opcode(ch_opcode),
        .reg_value(reg_value), .SW(SW), .HEX(HEX), .LEDR(LEDR), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [ND*7-1:0] exp_q[$];
    bit              m_valid = 1'b0;
    logic [31:0]     m_val = '0;
    logic [4:0]      m_mode = '0;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
            12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Display frame straight from positional notation.
    function automatic logic [ND*7-1:0] render(input logic [31:0] v, input bit hex);
        longint unsigned base = hex ? 16 : 10;
        longint unsigned lim = 1;
        longint unsigned p = 1;
        logic [ND*7-1:0] r;
        for (int i = 0; i < ND; i++) lim = lim * base;
        for (int i = 0; i < ND; i++) begin
            if (longint'(v) >= lim)   r[i*7 +: 7] = 7'b0111111;
            else if (i > 0 && v < p)  r[i*7 +: 7] = 7'h7F;
            else                      r[i*7 +: 7] = seg(int'((v / p) % base));
            p = p * base;
        end
        return r;
    endfunction

    function automatic logic [LED_W-1:0] exp_led(input bit converting);
        logic [LED_W-1:0] l = '0;
        logic [OP_W-1:0] op = '0;
        int sel = int'(SW[2:0]);
        if (SW[9]) return '1;
        if (sel < NUM_CH) op = ch_opcode[sel*OP_W +: OP_W];
        for (int i = 0; i < OP_W; i++) l[i] = op[OP_W-1-i];
        l[LED_W-1] = converting;
        return l;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called after every input change: queue a frame when the display is due to change.
    task automatic model_step();
        int sel = int'(SW[2:0]);
        logic [31:0] t;
        logic [4:0] md = {SW[9], SW[8], SW[2:0]};
        if (SW[9])            t = reg_value;
        else if (sel < NUM_CH) t = ch_value[sel*VAL_W +: VAL_W];
        else                  t = '0;
        if (!SW[7] && (!m_valid || t != m_val || md != m_mode)) begin
            exp_q.push_back(render(t, SW[8]));
            m_valid = 1'b1;
            m_val   = t;
            m_mode  = md;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: HEX may only change at a commit, which must match the next queued frame.
    logic [ND*7-1:0] prev_hex;
    bit              prev_busy = 1'b0;
    int              busy_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (busy) busy_cnt++;
            if (prev_busy && !busy) begin
                check("busy_len", 64'(busy_cnt), 64'd7);
                busy_cnt = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", 64'(HEX), 64'(prev_hex));
                end else begin
                    check("hex_frame", 64'(HEX), 64'(exp_q.pop_front()));
                end
            end else if (HEX != prev_hex) begin
                check("hex_change_outside_commit", 64'(HEX), 64'(prev_hex));
            end
        end
        prev_hex  = HEX;
        prev_busy = busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset held, channel 0 = 123 decimal.
        ch_value[0 +: VAL_W] = 32'd123;
        repeat (3) @(negedge clk);
        check("reset_hex", 64'(HEX), 64'(42'h3FF_FFFF_FFFF));
        check("reset_ledr", 64'(LEDR), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        model_step();
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #2;
            if (n == 0 && HEX != '1) n = i;
        end
        check("first_latency", 64'(n), 64'd9);

        // Hex register mode.
        @(negedge clk);
        SW = 10'h300;
        reg_value = 32'h0000ABCD;
        model_step();
        wait_cycles(12);
        check("ledr_reg_mode", 64'(LEDR), 64'h3FF);

        // Decimal boundaries: all nines, overflow, zero.
        @(negedge clk); SW = 10'h200; reg_value = 32'd999999; model_step(); wait_cycles(12);
        @(negedge clk); reg_value = 32'd1000000; model_step(); wait_cycles(12);
        @(negedge clk); reg_value = 32'd0; model_step(); wait_cycles(12);

        // Change during conversion: snapshot 5 commits, then 42.
        @(negedge clk); SW = 10'h000; ch_value[0 +: VAL_W] = 32'd5; model_step();
        repeat (4) @(posedge clk);
        @(negedge clk); ch_value[0 +: VAL_W] = 32'd42; model_step();
        wait_cycles(22);

        // Freeze.
        @(negedge clk); ch_value[0 +: VAL_W] = 32'd7; model_step(); wait_cycles(12);
        @(negedge clk); SW[7] = 1'b1; model_step();
        @(negedge clk); ch_value[0 +: VAL_W] = 32'd8; model_step();
        wait_cycles(25);
        check("freeze_hex", 64'(HEX), 64'(render(32'd7, 1'b0)));
        check("freeze_busy", 64'(busy), 64'd0);
        @(negedge clk); SW[7] = 1'b0; model_step(); wait_cycles(12);

        // Channel 3 opcode to LEDs, then reset mid-conversion.
        @(negedge clk);
        SW = 10'h003;
        ch_opcode[3*OP_W +: OP_W] = 7'b0000001;
        ch_value[3*VAL_W +: VAL_W] = 32'd31337;
        model_step();
        wait_cycles(4);
        check("ledr_busy_mid_conv", 64'(LEDR), 64'(exp_led(1'b1)));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_hex", 64'(HEX), 64'(42'h3FF_FFFF_FFFF));
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_ledr", 64'(LEDR), 64'd0);
        exp_q.delete();
        m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_step();
        wait_cycles(12);
        check("ledr_ch3_idle", 64'(LEDR), 64'(exp_led(1'b0)));

        // Randomized sweep.
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            for (int k = 0; k < NUM_CH; k++) begin
                ch_value[k*VAL_W +: VAL_W] = ($urandom_range(0, 3) == 0) ? $urandom
                                             : $urandom_range(0, 1_200_000);
                ch_opcode[k*OP_W +: OP_W]  = OP_W'($urandom);
            end
            reg_value = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 20_000_000);
            SW = '0;
            SW[9] = 1'($urandom_range(0, 1));
            SW[8] = 1'($urandom_range(0, 1));
            SW[7] = ($urandom_range(0, 7) == 0);
            SW[2:0] = 3'($urandom_range(0, 7));
            model_step();
            wait_cycles(12);
            check("ledr_random", 64'(LEDR), 64'(exp_led(1'b0)));
        end

        wait_cycles(12);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
